// File: rtl/decode_stage_pipelined.sv
// MIPS decode stage: IF/ID and ID/EX pipeline registers, register file, control decode,
// early branch/jump resolution with M-stage forwarding, and a syscall handshake FSM.
module decode_stage_pipelined #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int LINK_REG = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_d,
   input  logic              flush_d,
   input  logic              flush_e,
   input  logic [31:0]       instr_f,
   input  logic [DATA_W-1:0] pc_plus_4_f,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              fwd_a_d,
   input  logic              fwd_b_d,
   input  logic [DATA_W-1:0] alu_out_m,
   input  logic              syscall_ack,
   output logic [REG_AW-1:0] rs_d,
   output logic [REG_AW-1:0] rt_d,
   output logic              branch_d,
   output logic              pcsrc_d,
   output logic [DATA_W-1:0] branch_target_d,
   output logic              jump_d,
   output logic              jr_d,
   output logic [DATA_W-1:0] jump_target_d,
   output logic              syscall_busy,
   output logic              syscall_req,
   output logic [DATA_W-1:0] syscall_v0,
   output logic [DATA_W-1:0] syscall_a0,
   output logic [DATA_W-1:0] rd1_e,
   output logic [DATA_W-1:0] rd2_e,
   output logic [DATA_W-1:0] imm_e,
   output logic [REG_AW-1:0] rs_e,
   output logic [REG_AW-1:0] rt_e,
   output logic [REG_AW-1:0] rd_e,
   output logic [7:0]        ctrl_e
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_SYS   = 6'h0C;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic {SYS_IDLE = 1'b0, SYS_WAIT = 1'b1} sys_state_t;

   logic [31:0]       ifid_instr_q;
   logic [DATA_W-1:0] ifid_pc_q;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   sys_state_t        sys_state_q;
   logic              sys_req_q;
   logic [DATA_W-1:0] sys_v0_q, sys_a0_q;
   logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
   logic [REG_AW-1:0] rs_q, rt_q, rd_q;
   logic [7:0]        ctrl_q;

   logic [5:0]        op, funct;
   logic [REG_AW-1:0] rs_f, rt_f, rd_f;
   logic [DATA_W-1:0] imm_sx, rd1, rd2, a_val, b_val, link_val;
   logic [7:0]        ctrl_dec;
   logic              is_beq, is_bne, is_j, is_jal, is_jr, is_sys, link_we, busy;

   assign op     = ifid_instr_q[31:26];
   assign funct  = ifid_instr_q[5:0];
   assign rs_f   = REG_AW'(ifid_instr_q[25:21]);
   assign rt_f   = REG_AW'(ifid_instr_q[20:16]);
   assign rd_f   = REG_AW'(ifid_instr_q[15:11]);
   assign imm_sx = {{(DATA_W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

   // Register read with write-through bypass; r0 and unimplemented registers read zero.
   function automatic logic [DATA_W-1:0] rf_read(input logic [REG_AW-1:0] a);
      logic [DATA_W-1:0] v;
      if (a == '0 || int'(a) >= NUM_REGS) v = '0;
      else if (wb_we && wb_addr == a)     v = wb_data;
      else                                v = regs_q[a];
      return v;
   endfunction

   // Control decode; unknown opcodes and functs become bubbles.
   always_comb begin
      ctrl_dec = 8'h00;
      is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0;
      is_jr  = 1'b0; is_sys = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  ctrl_dec = 8'b1000_1010;
               FN_SUB:  ctrl_dec = 8'b1000_1110;
               FN_AND:  ctrl_dec = 8'b1000_1000;
               FN_OR:   ctrl_dec = 8'b1000_1001;
               FN_SLT:  ctrl_dec = 8'b1000_1111;
               FN_JR:   is_jr    = 1'b1;
               FN_SYS:  is_sys   = 1'b1;
               default: ctrl_dec = 8'h00;
            endcase
         end
         OP_LW:   ctrl_dec = 8'b1101_0010;
         OP_SW:   ctrl_dec = 8'b0011_0010;
         OP_ADDI: ctrl_dec = 8'b1001_0010;
         OP_BEQ:  begin ctrl_dec = 8'b0000_0110; is_beq = 1'b1; end
         OP_BNE:  begin ctrl_dec = 8'b0000_0110; is_bne = 1'b1; end
         OP_J:    is_j   = 1'b1;
         OP_JAL:  is_jal = 1'b1;
         default: ctrl_dec = 8'h00;
      endcase
   end

   assign rd1      = rf_read(rs_f);
   assign rd2      = rf_read(rt_f);
   assign a_val    = fwd_a_d ? alu_out_m : rd1;
   assign b_val    = fwd_b_d ? alu_out_m : rd2;
   assign link_val = ifid_pc_q + DATA_W'(4);
   assign link_we  = is_jal && !busy;

   assign busy = ((sys_state_q == SYS_IDLE) && is_sys && !stall_d) ||
                 ((sys_state_q == SYS_WAIT) && !syscall_ack);

   assign rs_d            = rs_f;
   assign rt_d            = rt_f;
   assign branch_d        = is_beq || is_bne;
   assign pcsrc_d         = (is_beq && (a_val == b_val)) || (is_bne && (a_val != b_val));
   assign branch_target_d = ifid_pc_q + {imm_sx[DATA_W-3:0], 2'b00};
   assign jump_d          = is_j || is_jal;
   assign jr_d            = is_jr;
   assign jump_target_d   = is_jr ? a_val
                                  : {ifid_pc_q[DATA_W-1:28], ifid_instr_q[25:0], 2'b00};
   assign syscall_busy    = busy;

   // IF/ID register: flush beats stall/syscall hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_instr_q <= 32'h0;
         ifid_pc_q    <= '0;
      end else if (flush_d) begin
         ifid_instr_q <= 32'h0;
      end else if (!(stall_d || busy)) begin
         ifid_instr_q <= instr_f;
         ifid_pc_q    <= pc_plus_4_f;
      end
   end

   // Register file; the JAL link write is issued last so it wins over a same-cycle writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         if (wb_we && wb_addr != '0 && int'(wb_addr) < NUM_REGS) regs_q[wb_addr] <= wb_data;
         if (link_we) regs_q[LINK_REG] <= link_val;
      end
   end

   // ID/EX register.
   always_ff @(posedge clk) begin
      if (reset || flush_e || stall_d || busy) begin
         rd1_q <= '0; rd2_q <= '0; imm_q <= '0;
         rs_q  <= '0; rt_q  <= '0; rd_q  <= '0;
         ctrl_q <= 8'h00;
      end else begin
         rd1_q <= rd1; rd2_q <= rd2; imm_q <= imm_sx;
         rs_q  <= rs_f; rt_q <= rt_f; rd_q <= rd_f;
         ctrl_q <= ctrl_dec;
      end
   end

   // Syscall handshake FSM with registered request and latched $v0/$a0.
   always_ff @(posedge clk) begin
      if (reset) begin
         sys_state_q <= SYS_IDLE;
         sys_req_q   <= 1'b0;
         sys_v0_q    <= '0;
         sys_a0_q    <= '0;
      end else begin
         case (sys_state_q)
            SYS_IDLE: begin
               if (is_sys && !stall_d) begin
                  sys_state_q <= SYS_WAIT;
                  sys_req_q   <= 1'b1;
                  sys_v0_q    <= rf_read(REG_AW'(2));
                  sys_a0_q    <= rf_read(REG_AW'(4));
               end else begin
                  sys_req_q   <= 1'b0;
               end
            end
            SYS_WAIT: begin
               if (flush_d || syscall_ack) begin
                  sys_state_q <= SYS_IDLE;
                  sys_req_q   <= 1'b0;
               end else begin
                  sys_req_q   <= 1'b1;
               end
            end
            default: begin
               sys_state_q <= SYS_IDLE;
               sys_req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign syscall_req = sys_req_q;
   assign syscall_v0  = sys_v0_q;
   assign syscall_a0  = sys_a0_q;
   assign rd1_e       = rd1_q;
   assign rd2_e       = rd2_q;
   assign imm_e       = imm_q;
   assign rs_e        = rs_q;
   assign rt_e        = rt_q;
   assign rd_e        = rd_q;
   assign ctrl_e      = ctrl_q;

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised next-generation MIPS decode stage: owns the IF/ID and ID/EX pipeline registers, register file, control decode, early branch/jump resolution with M-stage forwarding, and a syscall handshake FSM.
- Sits between fetch and execute.
- Drives fetch redirect (pcsrc/jump) and reports its own stall to the hazard unit.

Parameters:
- DATA_W, 32, datapath and register width.
- NUM_REGS, 32, register file depth; register 0 reads zero.
- REG_AW, 5, register address width; NUM_REGS <= 2**REG_AW.
- LINK_REG, 31, JAL link destination.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall_d  in  1  hold IF/ID (hazard unit).
- flush_d  in  1  clear IF/ID to bubble (taken branch/jump).
- flush_e  in  1  insert bubble into ID/EX.
- instr_f  in  32  fetched instruction.
- pc_plus_4_f  in  DATA_W  fetch PC+4.
- wb_we  in  1  writeback enable.
- wb_addr  in  REG_AW  writeback register.
- wb_data  in  DATA_W  writeback data.
- fwd_a_d, fwd_b_d  in  1 each  select alu_out_m for branch-compare rs/rt.
- alu_out_m  in  DATA_W  memory-stage ALU result.
- syscall_ack  in  1  syscall service complete.
- rs_d, rt_d  out  REG_AW  decode-stage source registers (to hazard unit).
- branch_d  out  1  BEQ/BNE in decode.
- pcsrc_d  out  1  branch taken.
- branch_target_d  out  DATA_W  branch target.
- jump_d  out  1  J/JAL.
- jr_d  out  1  JR.
- jump_target_d  out  DATA_W  J/JAL target, or forwarded rs for JR.
- syscall_busy  out  1  decode holding for syscall; the fetch PC must also hold.
- syscall_req  out  1  registered service request.
- syscall_v0, syscall_a0  out  DATA_W  latched $v0/$a0.
- rd1_e, rd2_e  out  DATA_W  ID/EX operands.
- imm_e  out  DATA_W  sign-extended immediate.
- rs_e, rt_e, rd_e  out  REG_AW  ID/EX register fields.
- ctrl_e  out  8  {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, alu_ctrl[2:0]}.

Behaviour:
- Reset: IF/ID instr=0 (NOP), pc=0; all ID/EX outputs 0; all registers 0; FSM IDLE; syscall_req=0; v0/a0=0.
- IF/ID update priority:
  - reset.
  - flush_d: instr=0.
  - stall_d or syscall_busy: hold.
  - otherwise load.
- Decoded opcodes:
  - R-type: add 010, sub 110, and 000, or 001, slt 111; funct 0x08 = JR; funct 0x0C = syscall.
  - lw, sw, beq, bne, addi, j, jal.
  - Any other opcode decodes as a bubble (ctrl=0).
- Register file:
  - Write at the rising edge when wb_we and wb_addr!=0.
  - Same-cycle read of the address being written returns wb_data (write-through bypass). Address 0 always reads 0.
- JAL: writes pc_plus_4_d+4 to LINK_REG at the same edge. If wb_we targets LINK_REG in the same cycle, the JAL value wins. JAL is ignored while syscall_busy.
- Branch compare:
  - A = fwd_a_d ? alu_out_m : rd1; B = fwd_b_d ? alu_out_m : rd2.
  - pcsrc_d = (beq & A==B) | (bne & A!=B); combinational, same cycle.
- Target arithmetic (mod 2**DATA_W):
  - branch_target_d = pc_plus_4_d + (signext(imm)<<2).
  - jump_target_d = {pc_plus_4_d[31:28], instr[25:0], 2'b00} for J/JAL; A for JR.
- ID/EX register: loads decode results every edge unless reset, flush_e, stall_d, or syscall_busy; any of these loads a bubble (all outputs 0).
- Syscall FSM:
  - IDLE: syscall in ID and !stall_d → syscall_busy=1 (combinational); latch v0 (reg 2) and a0 (reg 4) with bypass; next state WAIT.
  - WAIT: syscall_req=1, syscall_busy=1. On syscall_ack, syscall_busy drops that cycle, IF/ID loads the next instruction, and the next state is IDLE with req=0.
  - ack in IDLE: ignored.
  - flush_d in WAIT: abort to IDLE, req=0.
  - reset in WAIT: IDLE.
- Latency: decode results appear on the *_e outputs 1 cycle after the instruction is in IF/ID.

Test Plan:
- Write-through: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF; instr add rd=3, rs=5, rt=0 in ID → rd1_e=0xDEADBEEF next cycle, ctrl_e reg_write=1, reg_dst=1, alu_ctrl=010. With wb_addr=0 → rd1_e=0.
- Forwarded branch: beq rs=1, rt=2, regs differ, fwd_a_d=1, alu_out_m equals reg2, pc_plus_4=0x100, imm=3 → pcsrc_d=1, branch_target_d=0x10C. Repeat as bne → pcsrc_d=0.
- JAL: jal target=0x40 at pc_plus_4=0x1004, wb_we to reg 31 same cycle → reg31=0x1008; jump_target_d=0x100; jump_d=1.
- Syscall: v0=10, a0=7, syscall enters ID → syscall_busy=1 same cycle; syscall_req=1 from next cycle with v0/a0=10/7; IF/ID held 3 cycles; ack → next instruction loads, req=0, no retrigger; flush_d mid-WAIT → IDLE.
- Stall/flush priority: stall_d=1 and flush_d=1 together → IF/ID=0; stall_d alone → IF/ID held, ID/EX bubble; reset asserted mid-WAIT → all outputs 0, FSM IDLE.
